// File: rtl/uart_rx_frm.sv
// 8N1 UART receive front-end: synchronizer, start-bit qualification, framing
// and overrun detection, and a rdy/clr_rdy byte handshake.
module uart_rx_frm #(
    parameter int BAUD_CNT = 5208,
    parameter int HALF_CNT = BAUD_CNT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);

    localparam int CNT_W = $clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0] BAUD_LD = CNT_W'(BAUD_CNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECV,
        STOP,
        BRK
    } state_t;

    state_t           state, state_nxt;
    logic             rx_s1, rx_s2, rx_d;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [3:0]       bit_cnt, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       data_nxt;
    logic             rdy_nxt, frm_nxt, ovr_nxt;
    logic             fall, tick;

    assign fall = rx_d & ~rx_s2;
    assign tick = (baud_cnt == '0);

    // NOTE: the synchronizer resets to the idle-high line level so that leaving
    // reset can never look like a start-bit falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            rx_data  <= data_nxt;
            rdy      <= rdy_nxt;
            frm_err  <= frm_nxt;
            ovr      <= ovr_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = tick ? baud_cnt : baud_cnt - 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = rx_data;
        rdy_nxt   = rdy & ~clr_rdy;
        ovr_nxt   = ovr & ~clr_rdy;
        frm_nxt   = frm_err;

        case (state)
            IDLE: begin
                if (fall) begin
                    baud_nxt  = HALF_LD;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s2) begin
                        baud_nxt  = BAUD_LD;
                        bit_nxt   = '0;
                        state_nxt = RECV;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            RECV: begin
                if (tick) begin
                    shift_nxt = {rx_s2, shift[7:1]};
                    bit_nxt   = bit_cnt + 4'd1;
                    baud_nxt  = BAUD_LD;
                    if (bit_cnt == 4'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s2) begin
                        // Store wins over a simultaneous clr_rdy; ovr sees pre-edge rdy.
                        data_nxt  = shift;
                        rdy_nxt   = 1'b1;
                        ovr_nxt   = rdy;
                        frm_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        frm_nxt   = 1'b1;
                        state_nxt = BRK;
                    end
                end
            end
            BRK: begin
                if (rx_s2) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_frm.sv
// Directed bench for uart_rx_frm: table of frames plus hand-written sequences
// for glitch, break, back-to-back overrun, clear/store coincidence and reset.
module tb_uart_rx_frm;

    localparam int BAUD = 32;
    localparam int HALF = BAUD / 2;
    localparam int LAT  = 3 + HALF + 9 * BAUD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    logic rdy_prev = 1'b0;

    uart_rx_frm #(.BAUD_CNT(BAUD), .HALF_CNT(HALF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Remembers the edge count at which rdy was first seen high.
    always @(negedge clk) begin
        if (rdy && !rdy_prev) rise_cyc = cyc;
        rdy_prev = rdy;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         blen;
        int         hold;
        logic       clr;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_frm;
        logic       e_ovr;
        logic       lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Bit-bangs the first ncyc cycles of a frame (start, 8 data LSB first, stop).
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int blen, input int ncyc);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        start_cyc = cyc;
        rise_cyc  = -1;
        for (int c = 0; c < ncyc; c++) begin
            RX = bits[c / blen];
            @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_data, input logic e_rdy,
                              input logic e_frm, input logic e_ovr);
        check({tag, "_data"}, 32'(rx_data), 32'(e_data));
        check({tag, "_rdy"},  32'(rdy),     32'(e_rdy));
        check({tag, "_frm"},  32'(frm_err), 32'(e_frm));
        check({tag, "_ovr"},  32'(ovr),     32'(e_ovr));
    endtask

    initial begin
        vecs[0] = '{8'h47, 1'b1, BAUD,     0, 1'b1, 8'h47, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h53, 1'b1, BAUD,     0, 1'b1, 8'h53, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, BAUD,     0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, BAUD,     0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 1'b1, BAUD - 1, 0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, BAUD + 1, 0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h53, 1'b0, BAUD,   200, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h47, 1'b1, BAUD,     0, 1'b0, 8'h47, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'h53, 1'b1, BAUD,     0, 1'b1, 8'h53, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset held with the line toggling, then a long quiet idle.
        rst_n   = 1'b0;
        clr_rdy = 1'b0;
        RX      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            RX = ~RX;
            @(negedge clk);
        end
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        RX    = 1'b1;
        rst_n = 1'b1;
        rise_cyc = -1;
        idle(2000);
        check("reset_idle_rdy",  32'(rdy), 32'd0);
        check("reset_idle_rise", 32'(rise_cyc), 32'hFFFF_FFFF);

        for (int i = 0; i < 9; i++) begin
            drive_frame(vecs[i].d, vecs[i].stop, vecs[i].blen, 10 * vecs[i].blen);
            if (vecs[i].hold > 0) begin
                RX = 1'b0;
                repeat (vecs[i].hold) @(negedge clk);
            end
            idle(8);
            check_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rdy,
                       vecs[i].e_frm, vecs[i].e_ovr);
            if (vecs[i].lat)
                check_range($sformatf("vec%0d_lat", i), rise_cyc - start_cyc, LAT - 2, LAT + 2);
            if (vecs[i].clr) begin
                pulse_clr();
                check($sformatf("vec%0d_clr_rdy", i), 32'(rdy), 32'd0);
                check($sformatf("vec%0d_clr_ovr", i), 32'(ovr), 32'd0);
                check($sformatf("vec%0d_clr_frm", i), 32'(frm_err), 32'(vecs[i].e_frm));
            end
        end

        // Short low pulse must be rejected as a false start.
        RX = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        idle(4 * BAUD);
        check_outs("glitch", 8'h53, 1'b0, 1'b0, 1'b0);
        drive_frame(8'h47, 1'b1, BAUD, 10 * BAUD);
        idle(4);
        check_outs("post_glitch", 8'h47, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // Two frames with no gap and no clear in between.
        drive_frame(8'h47, 1'b1, BAUD, 10 * BAUD);
        drive_frame(8'h53, 1'b1, BAUD, 10 * BAUD);
        idle(4);
        check_outs("b2b", 8'h53, 1'b1, 1'b0, 1'b1);
        pulse_clr();
        check("b2b_clr_rdy", 32'(rdy), 32'd0);
        check("b2b_clr_ovr", 32'(ovr), 32'd0);

        // clr_rdy held through the store: the store must still raise rdy.
        clr_rdy = 1'b1;
        drive_frame(8'hC3, 1'b1, BAUD, 10 * BAUD);
        idle(4);
        clr_rdy = 1'b0;
        check("coin_rdy_seen", 32'(rise_cyc != -1), 32'd1);
        check("coin_data", 32'(rx_data), 32'hC3);
        check("coin_rdy_after", 32'(rdy), 32'd0);

        // Reset during data bit 4 aborts the frame.
        drive_frame(8'h47, 1'b1, BAUD, 10 * BAUD);
        idle(4);
        check("pre_rst_rdy", 32'(rdy), 32'd1);
        drive_frame(8'h53, 1'b1, BAUD, 5 * BAUD + 10);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        rise_cyc = -1;
        idle(12 * BAUD);
        check("mid_rst_nobyte", 32'(rise_cyc), 32'hFFFF_FFFF);
        drive_frame(8'h47, 1'b1, BAUD, 10 * BAUD);
        idle(4);
        check_outs("post_rst", 8'h47, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
